// File: rtl/video_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// video_timing_ctrl_if
// Configuration bus of the video timing controller.
//   cfg_we      : shadow register write strobe (master -> slave)
//   cfg_addr    : register index 0..7 (master -> slave)
//   cfg_wdata   : write data, 12 bits (master -> slave)
//   cfg_rdata   : shadow value at cfg_addr, combinational (slave -> master)
//   cfg_err     : one-cycle pulse, write rejected (slave -> master)
//   cfg_applied : one-cycle pulse, shadow copied to active (slave -> master)
// ---------------------------------------------------------------------------
interface video_timing_ctrl_if;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [11:0] cfg_wdata;
   logic [11:0] cfg_rdata;
   logic        cfg_err;
   logic        cfg_applied;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata,
      input  cfg_rdata, cfg_err, cfg_applied
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata,
      output cfg_rdata, cfg_err, cfg_applied
   );
endinterface

// File: rtl/video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// video_timing_ctrl
// Programmable raster timing generator. Eight 12-bit shadow fields are
// written over the cfg bus and copied into the active set when generation
// starts and at every frame boundary, so a frame never changes shape midway.
// Ports:
//   pix_clk     : pixel clock
//   rst_n       : asynchronous active-low reset
//   run_req     : level request to generate video
//   cfg         : configuration bus (slave modport of video_timing_ctrl_if)
//   running     : high while in RUN or DRAIN
//   hsync/vsync : active-high sync pulses
//   de          : data enable in the active area
//   pix_x/pix_y : active-area coordinates, 0 when de=0
//   frame_start : pulse aligned with the outputs of h=0,v=0
// ---------------------------------------------------------------------------
module video_timing_ctrl #(
   parameter logic [11:0] H_SYNC_DEF = 12'd96,
   parameter logic [11:0] H_BP_DEF   = 12'd48,
   parameter logic [11:0] H_ACT_DEF  = 12'd640,
   parameter logic [11:0] H_FP_DEF   = 12'd16,
   parameter logic [11:0] V_SYNC_DEF = 12'd2,
   parameter logic [11:0] V_BP_DEF   = 12'd33,
   parameter logic [11:0] V_ACT_DEF  = 12'd480,
   parameter logic [11:0] V_FP_DEF   = 12'd10
) (
   input  logic                pix_clk,
   input  logic                rst_n,
   input  logic                run_req,
   video_timing_ctrl_if.slave  cfg,
   output logic                running,
   output logic                hsync,
   output logic                vsync,
   output logic                de,
   output logic [11:0]         pix_x,
   output logic [11:0]         pix_y,
   output logic                frame_start
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Reset value of each register index.
   function automatic logic [11:0] def_val(input logic [2:0] idx);
      logic [11:0] val;
      case (idx)
         3'd0:    val = H_SYNC_DEF;
         3'd1:    val = H_BP_DEF;
         3'd2:    val = H_ACT_DEF;
         3'd3:    val = H_FP_DEF;
         3'd4:    val = V_SYNC_DEF;
         3'd5:    val = V_BP_DEF;
         3'd6:    val = V_ACT_DEF;
         3'd7:    val = V_FP_DEF;
         default: val = 12'd0;
      endcase
      return val;
   endfunction

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [11:0] shadow_r [8];
   logic [11:0] active_r [8];
   logic [13:0] h_cnt_r;
   logic [13:0] v_cnt_r;
   logic        cfg_err_r;
   logic        cfg_applied_r;

   logic [13:0] h_total_s;
   logic [13:0] v_total_s;
   logic [13:0] h_start_s;
   logic [13:0] h_end_s;
   logic [13:0] v_start_s;
   logic [13:0] v_end_s;
   logic        run_s;
   logic        wrap_h_s;
   logic        wrap_v_s;
   logic        boundary_s;
   logic        load_s;
   logic        cfg_ok_s;
   logic        hs_s;
   logic        vs_s;
   logic        de_s;
   logic [11:0] h_off_s;
   logic [11:0] v_off_s;

   // Totals and active-window edges in 14 bits so four 12-bit fields cannot overflow.
   assign h_total_s = {2'b00, active_r[0]} + {2'b00, active_r[1]}
                    + {2'b00, active_r[2]} + {2'b00, active_r[3]};
   assign v_total_s = {2'b00, active_r[4]} + {2'b00, active_r[5]}
                    + {2'b00, active_r[6]} + {2'b00, active_r[7]};
   assign h_start_s = {2'b00, active_r[0]} + {2'b00, active_r[1]};
   assign h_end_s   = h_start_s + {2'b00, active_r[2]};
   assign v_start_s = {2'b00, active_r[4]} + {2'b00, active_r[5]};
   assign v_end_s   = v_start_s + {2'b00, active_r[6]};

   assign run_s      = (state_r != ST_IDLE);
   // >= rather than == so a counter can never run away past the total.
   assign wrap_h_s   = (h_cnt_r >= (h_total_s - 14'd1));
   assign wrap_v_s   = (v_cnt_r >= (v_total_s - 14'd1));
   assign boundary_s = run_s & wrap_h_s & wrap_v_s;
   assign cfg_ok_s   = cfg.cfg_we & (cfg.cfg_wdata != 12'd0);

   assign cfg.cfg_rdata   = shadow_r[cfg.cfg_addr];
   assign cfg.cfg_err     = cfg_err_r;
   assign cfg.cfg_applied = cfg_applied_r;
   assign running         = run_s;

   // Next-state and shadow-to-active load decision.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (run_req) begin
               state_nxt_s = ST_RUN;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
               load_s      = 1'b0;
            end
         end
         ST_RUN: begin
            load_s = boundary_s;
            if (run_req) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // A drained frame that ends without a new request does not pick up shadow edits.
            load_s = boundary_s & run_req;
            if (run_req) begin
               state_nxt_s = ST_RUN;
            end else if (boundary_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            load_s      = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Raster counters: held at zero in IDLE, free-running otherwise.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_r <= 14'd0;
         v_cnt_r <= 14'd0;
      end else if (!run_s) begin
         h_cnt_r <= 14'd0;
         v_cnt_r <= 14'd0;
      end else if (wrap_h_s) begin
         h_cnt_r <= 14'd0;
         v_cnt_r <= wrap_v_s ? 14'd0 : (v_cnt_r + 14'd1);
      end else begin
         h_cnt_r <= h_cnt_r + 14'd1;
      end
   end

   // Shadow/active register file; the active copy samples the pre-write shadow.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            shadow_r[i] <= def_val(3'(i));
            active_r[i] <= def_val(3'(i));
         end
         cfg_err_r     <= 1'b0;
         cfg_applied_r <= 1'b0;
      end else begin
         if (load_s) begin
            for (int i = 0; i < 8; i++) begin
               active_r[i] <= shadow_r[i];
            end
         end
         if (cfg_ok_s) begin
            shadow_r[cfg.cfg_addr] <= cfg.cfg_wdata;
         end
         cfg_err_r     <= cfg.cfg_we & (cfg.cfg_wdata == 12'd0);
         cfg_applied_r <= load_s;
      end
   end

   // Video decode from the current counter state.
   always_comb begin
      hs_s    = (h_cnt_r < {2'b00, active_r[0]});
      vs_s    = (v_cnt_r < {2'b00, active_r[4]});
      de_s    = (h_cnt_r >= h_start_s) && (h_cnt_r < h_end_s) &&
                (v_cnt_r >= v_start_s) && (v_cnt_r < v_end_s);
      h_off_s = 12'(h_cnt_r - h_start_s);
      v_off_s = 12'(v_cnt_r - v_start_s);
   end

   // Registered video outputs, forced to zero outside RUN/DRAIN.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         de          <= 1'b0;
         pix_x       <= 12'd0;
         pix_y       <= 12'd0;
         frame_start <= 1'b0;
      end else if (run_s) begin
         hsync       <= hs_s;
         vsync       <= vs_s;
         de          <= de_s;
         pix_x       <= de_s ? h_off_s : 12'd0;
         pix_y       <= de_s ? v_off_s : 12'd0;
         frame_start <= (h_cnt_r == 14'd0) && (v_cnt_r == 14'd0);
      end else begin
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         de          <= 1'b0;
         pix_x       <= 12'd0;
         pix_y       <= 12'd0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_SYNC_DEF, 96, reset value of horizontal sync width in pixels.
- H_BP_DEF, 48, reset value of horizontal back porch.
- H_ACT_DEF, 640, reset value of horizontal active width.
- H_FP_DEF, 16, reset value of horizontal front porch.
- V_SYNC_DEF, 2, reset value of vertical sync width in lines.
- V_BP_DEF, 33, reset value of vertical back porch.
- V_ACT_DEF, 480, reset value of vertical active height.
- V_FP_DEF, 10, reset value of vertical front porch.
REQ-002 Ports, one per line: name, direction, width, meaning.
- pix_clk, in, 1, the single clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- run_req, in, 1, level request to generate video.
- cfg_we, in, 1, shadow register write strobe.
- cfg_addr, in, 3, register index: 0 H_SYNC, 1 H_BP, 2 H_ACT, 3 H_FP, 4 V_SYNC, 5 V_BP, 6 V_ACT, 7 V_FP.
- cfg_wdata, in, 12, write data.
- cfg_rdata, out, 12, shadow value at cfg_addr, combinational.
- cfg_err, out, 1, one-cycle pulse when a write is rejected.
- cfg_applied, out, 1, one-cycle pulse when shadow is copied to active.
- running, out, 1, high in RUN or DRAIN.
- hsync, out, 1, active-high horizontal sync.
- vsync, out, 1, active-high vertical sync.
- de, out, 1, data enable (active pixel).
- pix_x, out, 12, active-area column, 0 when de=0.
- pix_y, out, 12, active-area row, 0 when de=0.
- frame_start, out, 1, pulse coincident with outputs for h=0,v=0.

Function
REQ-003 Shadow registers shall hold 8 x 12-bit timing fields; a write with cfg_wdata=0 shall be ignored and cfg_err shall pulse on the next cycle.
REQ-004 Active registers shall drive counting; h_total = sum of H fields, v_total = sum of V fields, computed in 14 bits.
REQ-005 FSM states: IDLE, RUN, DRAIN.
REQ-006 IDLE: h_cnt=v_cnt=0, held; run_req=1 -> RUN next edge, shadow copied to active, cfg_applied pulses.
REQ-007 RUN: h_cnt increments each cycle, wraps at h_total-1 to 0 and increments v_cnt; v_cnt wraps at v_total-1.
REQ-008 Frame boundary is the cycle with h_cnt=h_total-1 and v_cnt=v_total-1; there shadow shall be copied to active and cfg_applied shall pulse.
REQ-009 RUN with run_req=0 -> DRAIN; DRAIN completes the current frame, then goes to IDLE at the frame boundary, with no shadow copy.
REQ-010 DRAIN with run_req=1 shall return to RUN without interrupting counting.
REQ-011 A shadow write in the frame-boundary cycle shall be visible in shadow, but active shall receive the pre-write value; the new value applies at the next boundary.
REQ-012 hsync shall be (h_cnt < H_SYNC); vsync shall be (v_cnt < V_SYNC).
REQ-013 de shall be high when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT and the equivalent vertical condition holds.
REQ-014 pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) when de=1.
REQ-015 All video outputs shall be registered with 1-cycle latency from counter state; in IDLE they shall be 0.
REQ-016 frame_start shall pulse once per frame, including the first frame after IDLE->RUN.

Reset
REQ-017 rst_n=0 shall immediately force: state IDLE, counters 0, all outputs 0, shadow and active = *_DEF parameters.
REQ-018 Reset mid-frame shall abort the frame with no further sync pulses until a new run_req.

Verification
REQ-019 Defaults, run_req=1 held -> frame_start period 420000 cycles; hsync high 96 of every 800 cycles; 640x480 de=1 cycles per frame.
REQ-020 Write H_ACT=320 mid-frame -> the current frame keeps 800-cycle lines; after cfg_applied, lines are 480 cycles long.
REQ-021 Write V_FP=0 -> cfg_err pulses once, cfg_rdata at addr 7 stays 10, timing unchanged.
REQ-022 Drop run_req at line 100 -> frame completes to line 524, running falls, outputs 0; re-raise run_req in DRAIN -> no gap between frames.
REQ-023 Write at the exact boundary cycle -> cfg_rdata shows the new value, but the next frame uses the old value; the value applies one frame later.
REQ-024 Assert rst_n=0 at h=500,v=200 -> outputs 0 asynchronously; shadow registers read back defaults.
